// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned AW_DEF   = 32;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Saturating increment of the fetch starvation counter.
  function automatic logic [STARVE_W-1:0] starve_inc(
    input logic [STARVE_W-1:0] cnt,
    input logic [STARVE_W-1:0] max_cnt
  );
    return (cnt >= max_cnt) ? max_cnt : cnt + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports.
// Data wins ties unless a live fetch has already been passed over
// MAX_STARVE times in a row.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_abort,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  // hazard unit
  output logic          stall_if,
  output logic          stall_mem,
  // memory side
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata
);

  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_STARVE);

  arb_state_e          state_q,   state_d;
  logic                abort_q,   abort_d;
  logic [STARVE_W-1:0] starve_q,  starve_d;
  logic                m_req_q,   m_req_d;
  logic                m_we_q,    m_we_d;
  logic [AW-1:0]       m_addr_q,  m_addr_d;
  logic [DW-1:0]       m_wdata_q, m_wdata_d;
  logic                i_done_q,  i_done_d;
  logic [DW-1:0]       i_rdata_q, i_rdata_d;
  logic                d_done_q,  d_done_d;
  logic [DW-1:0]       d_rdata_q, d_rdata_d;

  logic fetch_live;
  logic grant_data;
  logic grant_fetch;
  logic fetch_killed;

  // Next-state, grant selection, starvation bookkeeping and response capture.
  always_comb begin
    state_d      = state_q;
    abort_d      = abort_q;
    starve_d     = starve_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_done_d     = 1'b0;
    d_rdata_d    = d_rdata_q;

    fetch_live   = i_req & ~i_abort;
    grant_data   = d_req & ~(i_req & (starve_q == MAX_CNT));
    grant_fetch  = ~grant_data & fetch_live;
    // an abort arriving together with the ack still kills the response
    fetch_killed = abort_q | i_abort;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d   = ST_DBUSY;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (fetch_live) begin
            starve_d = starve_inc(starve_q, MAX_CNT);
          end else if (!i_req) begin
            starve_d = '0;
          end
        end else if (grant_fetch) begin
          state_d   = ST_IBUSY;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          starve_d  = '0;
        end else if (!i_req) begin
          starve_d = '0;
        end
      end

      ST_IBUSY: begin
        if (i_abort) begin
          abort_d = 1'b1;
        end
        if (m_ack) begin
          state_d = ST_RESP;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (!fetch_killed) begin
            i_done_d  = 1'b1;
            i_rdata_d = m_rdata;
          end
        end
      end

      ST_DBUSY: begin
        if (m_ack) begin
          state_d  = ST_RESP;
          m_req_d  = 1'b0;
          m_we_d   = 1'b0;
          d_done_d = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      abort_q   <= 1'b0;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_done_q  <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      abort_q   <= abort_d;
      starve_q  <= starve_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_done_q  <= i_done_d;
      i_rdata_q <= i_rdata_d;
      d_done_q  <= d_done_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_done  = i_done_q;
  assign i_rdata = i_rdata_q;
  assign d_done  = d_done_q;
  assign d_rdata = d_rdata_q;

  // Stalls follow the live request; forced low while reset is held.
  assign stall_if  = rst_n & i_req & ~i_done_q;
  assign stall_mem = rst_n & d_req & ~d_done_q;

endmodule
